// File: rtl/j11bus_if.sv
// J11 bus and I/O-page signal bundle.
// The slave modport is the bus controller's view; the master modport is the
// view of whatever drives requests and answers I/O-page accesses.
interface j11bus_if;
  logic        busreq;
  logic        buswr;
  logic        busgp;
  logic        busirq;
  logic [21:0] busaddr;
  logic [15:0] buswdata;
  logic [1:0]  buswstrb;
  logic        busack;
  logic [15:0] busrdata;
  logic        buserr;
  logic [15:0] irqvec;
  logic        iorq;
  logic        iowr;
  logic [12:0] ioaddr;
  logic [15:0] iowdata;
  logic [1:0]  iowstrb;
  logic        ioack;
  logic [15:0] iordata;

  modport slave (
    input  busreq, buswr, busgp, busirq, busaddr, buswdata, buswstrb, irqvec,
    input  ioack, iordata,
    output busack, busrdata, buserr,
    output iorq, iowr, ioaddr, iowdata, iowstrb
  );

  modport master (
    output busreq, buswr, busgp, busirq, busaddr, buswdata, buswstrb, irqvec,
    output ioack, iordata,
    input  busack, busrdata, buserr,
    input  iorq, iowr, ioaddr, iowdata, iowstrb
  );
endinterface

// File: rtl/j11bus.sv
// J11 bus controller: decodes one request at a time into local RAM, the
// I/O page (with an ioack timeout), or an immediate GP/IRQ/NXM completion,
// and answers with a single-cycle busack.
module j11bus #(
  parameter int AW      = 15,
  parameter int TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      rst,
  j11bus_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          ack_q;
  logic          err_q;
  logic [15:0]   rdata_q;
  logic          iorq_q;

  // Latched request fields; pure data, only the accept condition gates them.
  logic          req_wr;
  logic [15:0]   req_wdata;
  logic [1:0]    req_wstrb;
  logic [12:0]   req_ioaddr;
  logic [AW-1:0] req_widx;

  logic [15:0]   ram [0:(1<<AW)-1];

  logic accept;
  logic io_page;
  logic mem_hit;

  assign accept  = (state == S_IDLE) && bus.busreq && !rst;
  assign io_page = (bus.busaddr[21:13] == 9'h1FF);
  assign mem_hit = ((bus.busaddr >> (AW + 1)) == 22'd0);

  // Capture the request on acceptance; held stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_wr     <= bus.buswr;
      req_wdata  <= bus.buswdata;
      req_wstrb  <= bus.buswstrb;
      req_ioaddr <= bus.busaddr[12:0];
      req_widx   <= bus.busaddr[AW:1];
    end
  end

  // Byte-masked RAM write in the MEM cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_MEM) && req_wr) begin
      if (req_wstrb[0]) ram[req_widx][7:0]  <= req_wdata[7:0];
      if (req_wstrb[1]) ram[req_widx][15:8] <= req_wdata[15:8];
    end
  end

  // Transaction FSM; busack/busrdata/buserr are registered on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'd0;
      iorq_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.busreq) begin
            if (bus.busirq) begin
              state   <= S_DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= bus.irqvec;
            end else if (bus.busgp) begin
              state   <= S_DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= 16'd0;
            end else if (io_page) begin
              state  <= S_IO;
              iorq_q <= 1'b1;
              cnt    <= '0;
            end else if (mem_hit) begin
              state <= S_MEM;
            end else begin
              // Nonexistent memory: error, no write, zero data.
              state   <= S_DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 16'd0;
            end
          end
        end
        S_MEM: begin
          state   <= S_DONE;
          ack_q   <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= req_wr ? 16'd0 : ram[req_widx];
        end
        S_IO: begin
          // ioack wins over a coinciding timeout.
          if (bus.ioack) begin
            state   <= S_DONE;
            iorq_q  <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= req_wr ? 16'd0 : bus.iordata;
          end else if (cnt == TLAST) begin
            state   <= S_DONE;
            iorq_q  <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 16'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          err_q   <= 1'b0;
          rdata_q <= 16'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busack   = ack_q;
  assign bus.buserr   = err_q;
  assign bus.busrdata = rdata_q;
  assign bus.iorq     = iorq_q;
  assign bus.iowr     = req_wr;
  assign bus.ioaddr   = req_ioaddr;
  assign bus.iowdata  = req_wdata;
  assign bus.iowstrb  = req_wstrb;

endmodule

// File: tb/tb_j11bus.sv
// Scoreboard bench for j11bus: stimulus pushes the expected completion
// (cycle, data, error) and a negedge monitor pops it when busack appears.
module tb_j11bus;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  j11bus_if bus ();

  j11bus #(.AW(15), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every busack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.busack === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL spurious_ack: got busack at cyc %0d, want none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc != e.cyc || bus.busrdata !== e.rdata || bus.buserr !== e.err) begin
          errs++;
          $display("FAIL %s: got cyc=%0d rdata=%h err=%b, want cyc=%0d rdata=%h err=%b",
                   e.name, cyc, bus.busrdata, bus.buserr, e.cyc, e.rdata, e.err);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic gp, input logic irq,
                       input logic [21:0] a, input logic [15:0] wd, input logic [1:0] ws,
                       input bit expect_ack, input int lat,
                       input logic [15:0] er, input logic ee, input string nm);
    exp_t e;
    @(posedge clk); #1;
    bus.busreq   = 1'b1;
    bus.buswr    = wr;
    bus.busgp    = gp;
    bus.busirq   = irq;
    bus.busaddr  = a;
    bus.buswdata = wd;
    bus.buswstrb = ws;
    if (expect_ack) begin
      e.cyc = cyc + lat; e.rdata = er; e.err = ee; e.name = nm;
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.busreq = 1'b0;
    bus.busgp  = 1'b0;
    bus.busirq = 1'b0;
  endtask

  task automatic drain(input int max, input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      errs++;
      $display("FAIL %s_timeout: got %0d pending acks, want 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic wait_iorq(input string nm);
    int n;
    n = 0;
    while (bus.iorq !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, "_iorq"}, {31'd0, bus.iorq}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.busreq = 1'b1; bus.buswr = 1'b1; bus.busgp = 1'b0; bus.busirq = 1'b0;
    bus.busaddr = 22'o000100; bus.buswdata = 16'hDEAD; bus.buswstrb = 2'b11;
    bus.irqvec = 16'o000060; bus.ioack = 1'b0; bus.iordata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    bus.busreq = 1'b0;
    check("rst_busack",   {31'd0, bus.busack}, 32'd0);
    check("rst_buserr",   {31'd0, bus.buserr}, 32'd0);
    check("rst_busrdata", {16'd0, bus.busrdata}, 32'd0);
    check("rst_iorq",     {31'd0, bus.iorq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-word write/readback
    issue(1, 0, 0, 22'o000100, 16'hA5C3, 2'b11, 1, 2, 16'h0000, 0, "mem_wr_a5c3");
    drain(10, "mem_wr_a5c3");
    issue(0, 0, 0, 22'o000101, 16'h0000, 2'b00, 1, 2, 16'hA5C3, 0, "mem_rd_a5c3");
    drain(10, "mem_rd_a5c3");

    // Byte strobes
    issue(1, 0, 0, 22'o000200, 16'hFFFF, 2'b11, 1, 2, 16'h0000, 0, "mem_wr_ffff");
    drain(10, "mem_wr_ffff");
    issue(1, 0, 0, 22'o000200, 16'h1234, 2'b01, 1, 2, 16'h0000, 0, "mem_wr_lo");
    drain(10, "mem_wr_lo");
    issue(0, 0, 0, 22'o000200, 16'h0000, 2'b00, 1, 2, 16'hFF34, 0, "mem_rd_ff34");
    drain(10, "mem_rd_ff34");
    issue(1, 0, 0, 22'o000200, 16'hABCD, 2'b10, 1, 2, 16'h0000, 0, "mem_wr_hi");
    drain(10, "mem_wr_hi");
    issue(0, 0, 0, 22'o000200, 16'h0000, 2'b00, 1, 2, 16'hAB34, 0, "mem_rd_ab34");
    drain(10, "mem_rd_ab34");

    // NXM back-to-back, write aliasing a RAM word must not land
    issue(0, 0, 0, 22'o17000000, 16'h0000, 2'b00, 1, 1, 16'h0000, 1, "nxm_rd");
    issue(1, 0, 0, 22'o17000100, 16'h0000, 2'b11, 1, 1, 16'h0000, 1, "nxm_wr");
    drain(10, "nxm");
    issue(0, 0, 0, 22'o000100, 16'h0000, 2'b00, 1, 2, 16'hA5C3, 0, "nxm_ram_kept");
    drain(10, "nxm_ram_kept");

    // GP and interrupt acknowledge
    issue(0, 1, 0, 22'o000100, 16'h0000, 2'b00, 1, 1, 16'h0000, 0, "gp");
    issue(0, 0, 1, 22'o000100, 16'h0000, 2'b00, 1, 1, 16'o000060, 0, "irq");
    drain(10, "gp_irq");

    // busreq during MEM is ignored
    issue(1, 0, 0, 22'o000300, 16'h0F0F, 2'b11, 1, 2, 16'h0000, 0, "mem_wr_0f0f");
    bus.busreq = 1'b1; bus.buswr = 1'b1; bus.busaddr = 22'o000100; bus.buswdata = 16'h0000;
    @(posedge clk); #1;
    bus.busreq = 1'b0;
    drain(10, "mem_wr_0f0f");
    issue(0, 0, 0, 22'o000100, 16'h0000, 2'b00, 1, 2, 16'hA5C3, 0, "ign_mem_kept");
    drain(10, "ign_mem_kept");
    issue(0, 0, 0, 22'o000300, 16'h0000, 2'b00, 1, 2, 16'h0F0F, 0, "mem_rd_0f0f");
    drain(10, "mem_rd_0f0f");

    // I/O read acked in the fifth I/O cycle, with a stray busreq in between
    issue(0, 0, 0, 22'o17777560, 16'h0000, 2'b00, 1, 6, 16'h0080, 0, "io_rd");
    wait_iorq("io_rd");
    check("io_rd_ioaddr", {19'd0, bus.ioaddr}, {19'd0, 13'o17560});
    check("io_rd_iowr", {31'd0, bus.iowr}, 32'd0);
    @(posedge clk); #1;
    bus.busreq = 1'b1; bus.busirq = 1'b1;
    @(posedge clk); #1;
    bus.busreq = 1'b0; bus.busirq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.ioack = 1'b1; bus.iordata = 16'h0080;
    @(posedge clk); #1;
    bus.ioack = 1'b0; bus.iordata = 16'hFFFF;
    check("io_rd_iorq_drop", {31'd0, bus.iorq}, 32'd0);
    drain(10, "io_rd");

    // I/O write acked immediately
    issue(1, 0, 0, 22'o17777566, 16'h1357, 2'b10, 1, 2, 16'h0000, 0, "io_wr");
    check("io_wr_iowr", {31'd0, bus.iowr}, 32'd1);
    check("io_wr_ioaddr", {19'd0, bus.ioaddr}, {19'd0, 13'o17566});
    check("io_wr_iowdata", {16'd0, bus.iowdata}, 32'h1357);
    check("io_wr_iowstrb", {30'd0, bus.iowstrb}, 32'd2);
    bus.ioack = 1'b1; bus.iordata = 16'hBEEF;
    @(posedge clk); #1;
    bus.ioack = 1'b0;
    drain(10, "io_wr");

    // I/O timeout
    issue(0, 0, 0, 22'o17777560, 16'h0000, 2'b00, 1, TO + 1, 16'h0000, 1, "io_timeout");
    drain(TO + 20, "io_timeout");

    // Reset while in I/O aborts without an ack
    issue(0, 0, 0, 22'o17777560, 16'h0000, 2'b00, 0, 0, 16'h0000, 0, "io_rst");
    wait_iorq("io_rst");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("io_rst_iorq", {31'd0, bus.iorq}, 32'd0);
    check("io_rst_busack", {31'd0, bus.busack}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    issue(0, 0, 0, 22'o000300, 16'h0000, 2'b00, 1, 2, 16'h0F0F, 0, "post_rst_rd");
    drain(10, "post_rst_rd");

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
